// File: rtl/hls_run_sequencer.sv
// hls_run_sequencer
//   On-chip start/done harness for the HLS kernel. Runs NUM_RUNS back-to-back
//   kernel invocations. For each run it fetches the expected return value from
//   a vector RAM, pulses the kernel start, counts cycles until done, compares
//   the return value and keeps pass/fail/timeout statistics.
//
// Ports:
//   clock         system clock
//   reset         asynchronous, active-low reset
//   go            single-cycle request to start a sequence (ignored while busy)
//   dut_start     one-cycle start pulse to the kernel
//   dut_done      kernel done
//   dut_return    kernel return value
//   vec_addr      expected-vector RAM address
//   vec_rdata     expected-vector RAM data, valid one cycle after vec_addr
//   busy          sequence in progress
//   finished      one-cycle pulse at sequence end
//   result_valid  one-cycle pulse per completed (or timed-out) run
//   result_pass   pass/fail of that run, valid with result_valid
//   run_idx       index of current/last run
//   last_cycles   start-to-done cycle count of the last completed run
//   pass_cnt      runs passed
//   fail_cnt      runs failed, including a timed-out run
//   timed_out     sticky, set when a run hits TIMEOUT
module hls_run_sequencer #(
  parameter int unsigned RET_W    = 32,
  parameter int unsigned NUM_RUNS = 4,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned CYC_W    = 32,
  parameter int unsigned TIMEOUT  = 200000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  output logic              dut_start,
  input  logic              dut_done,
  input  logic [RET_W-1:0]  dut_return,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [RET_W-1:0]  vec_rdata,
  output logic              busy,
  output logic              finished,
  output logic              result_valid,
  output logic              result_pass,
  output logic [ADDR_W-1:0] run_idx,
  output logic [CYC_W-1:0]  last_cycles,
  output logic [ADDR_W:0]   pass_cnt,
  output logic [ADDR_W:0]   fail_cnt,
  output logic              timed_out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_RUNS - 1);
  localparam logic [CYC_W-1:0]  TMO_CYC  = CYC_W'(TIMEOUT);

  logic [2:0]       state;
  logic [RET_W-1:0] expected;
  logic [RET_W-1:0] ret_cap;
  logic [CYC_W-1:0] counter;
  logic             tmo_pulse;  // result strobe for a timed-out run, shown in DONE
  logic             match;

  assign match = (ret_cap == expected);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      expected    <= '0;
      ret_cap     <= '0;
      counter     <= '0;
      tmo_pulse   <= 1'b0;
      run_idx     <= '0;
      last_cycles <= '0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      timed_out   <= 1'b0;
    end else begin
      tmo_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            timed_out   <= 1'b0;
            last_cycles <= '0;
            run_idx     <= '0;
            state       <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LAUNCH;
        S_LAUNCH: begin
          expected <= vec_rdata;
          counter  <= CYC_W'(1);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (dut_done) begin
            ret_cap     <= dut_return;
            last_cycles <= counter;
            state       <= S_CHECK;
          end else if (counter == TMO_CYC) begin
            // Abort the whole sequence; remaining runs are not started.
            timed_out <= 1'b1;
            fail_cnt  <= fail_cnt + (ADDR_W+1)'(1);
            tmo_pulse <= 1'b1;
            state     <= S_DONE;
          end else begin
            counter <= counter + CYC_W'(1);
          end
        end
        S_CHECK: begin
          if (match) pass_cnt <= pass_cnt + (ADDR_W+1)'(1);
          else       fail_cnt <= fail_cnt + (ADDR_W+1)'(1);
          if (run_idx == LAST_IDX) begin
            state <= S_DONE;
          end else begin
            run_idx <= run_idx + ADDR_W'(1);
            state   <= S_FETCH;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Decoded from state so that an asynchronous reset drops them immediately.
  assign dut_start    = (state == S_LAUNCH);
  assign busy         = (state != S_IDLE);
  assign finished     = (state == S_DONE);
  assign result_valid = (state == S_CHECK) || tmo_pulse;
  assign result_pass  = (state == S_CHECK) && match;
  assign vec_addr     = run_idx;

endmodule

// File: tb/tb_hls_run_sequencer.sv
module tb_hls_run_sequencer;

  localparam int unsigned TMO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        go = 1'b0;
  logic        spur_done = 1'b0;
  logic        dut_start, dut_done;
  logic [31:0] dut_return;
  logic [7:0]  vec_addr;
  logic [31:0] vec_rdata;
  logic        busy, finished, result_valid, result_pass, timed_out;
  logic [7:0]  run_idx;
  logic [31:0] last_cycles;
  logic [8:0]  pass_cnt, fail_cnt;

  always #5 clock = ~clock;

  hls_run_sequencer #(.RET_W(32), .NUM_RUNS(4), .ADDR_W(8), .CYC_W(32), .TIMEOUT(TMO)) u_dut (
    .clock(clock), .reset(reset), .go(go), .dut_start(dut_start), .dut_done(dut_done),
    .dut_return(dut_return), .vec_addr(vec_addr), .vec_rdata(vec_rdata), .busy(busy),
    .finished(finished), .result_valid(result_valid), .result_pass(result_pass),
    .run_idx(run_idx), .last_cycles(last_cycles), .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt), .timed_out(timed_out)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Vector RAM (one-cycle read latency) and kernel tables
  logic [31:0] vec_mem [0:3];
  logic [31:0] ret_tab [0:3];
  int unsigned lat_tab [0:3];   // 0 = kernel never asserts done

  always @(posedge clock) vec_rdata <= vec_mem[vec_addr[1:0]];

  // Kernel: done is high exactly lat cycles after the start cycle
  int unsigned k_cnt, k_n;
  logic [31:0] k_ret;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      k_cnt <= 0; k_n <= 0; k_ret <= '0;
    end else if (go && !busy) begin
      k_n <= 0;
    end else if (dut_start) begin
      k_ret <= ret_tab[k_n[1:0]];
      k_cnt <= lat_tab[k_n[1:0]];
      k_n   <= k_n + 1;
    end else if (k_cnt != 0) begin
      k_cnt <= k_cnt - 1;
    end
  end
  assign dut_done   = (k_cnt == 1) || spur_done;
  assign dut_return = k_ret;

  // Sequence-level model: expected per-run results and end-of-sequence stats
  typedef struct { bit pass; bit tmo; int unsigned idx; int unsigned lat; } exp_t;
  exp_t exp_q[$];
  int unsigned m_pass, m_fail, m_last, m_starts;
  bit m_tmo;

  task automatic plan();
    exp_q.delete();
    m_pass = 0; m_fail = 0; m_last = 0; m_starts = 0; m_tmo = 0;
    for (int i = 0; i < 4; i++) begin
      m_starts = i + 1;
      if (lat_tab[i] == 0) begin
        exp_q.push_back('{pass: 1'b0, tmo: 1'b1, idx: i, lat: TMO});
        m_fail++;
        m_tmo = 1;
        break;
      end
      exp_q.push_back('{pass: (ret_tab[i] == vec_mem[i]), tmo: 1'b0, idx: i, lat: lat_tab[i]});
      if (ret_tab[i] == vec_mem[i]) m_pass++; else m_fail++;
      m_last = lat_tab[i];
    end
  endtask

  // Compare process
  int unsigned seq_starts = 0;
  int unsigned since_start = 0;
  int unsigned fin_seen = 0;
  logic prev_start = 1'b0, prev_fin = 1'b0;
  exp_t e;
  always @(negedge clock) begin
    if (reset) begin
      if (go && !busy) seq_starts = 0;
      if (dut_start) begin
        chk("start_width", prev_start, 0);
        chk("start_busy", busy, 1);
        seq_starts++;
        since_start = 0;
      end else begin
        since_start++;
      end
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          chk("rv_extra", result_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rv_pass", result_pass, e.pass);
          chk("rv_idx", run_idx, e.idx);
          chk("rv_latency", since_start, e.lat + 1);
          if (!e.tmo) chk("rv_cycles", last_cycles, e.lat);
        end
      end
      if (finished) begin
        chk("fin_width", prev_fin, 0);
        chk("fin_q_left", exp_q.size(), 0);
        chk("fin_pass_cnt", pass_cnt, m_pass);
        chk("fin_fail_cnt", fail_cnt, m_fail);
        chk("fin_timed_out", timed_out, m_tmo);
        chk("fin_last_cycles", last_cycles, m_last);
        chk("fin_starts", seq_starts, m_starts);
        fin_seen++;
      end
      prev_start = dut_start;
      prev_fin   = finished;
    end else begin
      prev_start = 1'b0;
      prev_fin   = 1'b0;
    end
  end

  task automatic pulse_go();
    @(posedge clock); #1 go = 1'b1;
    @(posedge clock); #1 go = 1'b0;
  endtask

  task automatic run_seq(input bit mid_go);
    int unsigned f0;
    bit done;
    plan();
    f0 = fin_seen;
    pulse_go();
    chk("go_busy", busy, 1);
    chk("go_clr_pass", pass_cnt, 0);
    chk("go_clr_fail", fail_cnt, 0);
    chk("go_clr_tmo", timed_out, 0);
    if (mid_go) begin
      repeat (4) @(posedge clock);
      #1 go = 1'b1;
      @(posedge clock); #1 go = 1'b0;
    end
    done = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clock);
      if (fin_seen != f0) begin done = 1; break; end
    end
    if (!done) chk("fin_wait_expired", fin_seen - f0, 1);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk(name, {dut_start, busy, finished, result_valid, result_pass, timed_out,
               vec_addr, run_idx, pass_cnt, fail_cnt}, 0);
    chk({name, "_cycles"}, last_cycles, 0);
  endtask

  initial begin
    bit hit;
    int unsigned f0;
    #3 chk_zero("reset_outs");
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // All pass, first run done 5 cycles after start
    vec_mem = '{32'h2A, 32'h10, 32'h20, 32'h30};
    ret_tab = '{32'h2A, 32'h10, 32'h20, 32'h30};
    lat_tab = '{5, 3, 2, 4};
    run_seq(0);
    chk("s1_pass_cnt", pass_cnt, 4);
    chk("s1_fail_cnt", fail_cnt, 0);
    chk("s1_last_cycles", last_cycles, 4);

    // Off-by-one return on run 0, with a go pulse while busy
    ret_tab = '{32'h2B, 32'h10, 32'h20, 32'h30};
    lat_tab = '{1, 1, 1, 1};
    run_seq(1);
    chk("s2_pass_cnt", pass_cnt, 3);
    chk("s2_fail_cnt", fail_cnt, 1);
    chk("s2_timed_out", timed_out, 0);

    // Mixed latencies, one mismatch on run 1
    vec_mem = '{32'd1, 32'd2, 32'd3, 32'd4};
    ret_tab = '{32'd1, 32'd9, 32'd3, 32'd4};
    lat_tab = '{1, 2, 3, 7};
    run_seq(0);
    chk("s3_pass_cnt", pass_cnt, 3);
    chk("s3_fail_cnt", fail_cnt, 1);
    chk("s3_run_idx", run_idx, 3);
    chk("s3_last_cycles", last_cycles, 7);
    chk("s3_starts", seq_starts, 4);

    // Run 1 hangs: timeout aborts the sequence
    vec_mem = '{32'd5, 32'd6, 32'd7, 32'd8};
    ret_tab = '{32'd5, 32'd6, 32'd7, 32'd8};
    lat_tab = '{2, 0, 1, 1};
    run_seq(0);
    chk("s4_timed_out", timed_out, 1);
    chk("s4_pass_cnt", pass_cnt, 1);
    chk("s4_fail_cnt", fail_cnt, 1);
    chk("s4_run_idx", run_idx, 1);
    chk("s4_last_cycles", last_cycles, 2);
    chk("s4_starts", seq_starts, 2);

    // Reset during WAIT of run 1
    lat_tab = '{3, 0, 1, 1};
    plan();
    pulse_go();
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      if (seq_starts >= 2) begin hit = 1; break; end
    end
    if (!hit) chk("rst_wait_expired", seq_starts, 2);
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    #1 chk_zero("midrun_reset_outs");
    exp_q.delete();
    @(posedge clock); #1 reset = 1'b1;

    // Fresh sequence after reset
    vec_mem = '{32'd1, 32'd2, 32'd3, 32'd4};
    ret_tab = '{32'd1, 32'd9, 32'd3, 32'd4};
    lat_tab = '{1, 2, 3, 7};
    run_seq(0);
    chk("s5_pass_cnt", pass_cnt, 3);
    chk("s5_fail_cnt", fail_cnt, 1);
    chk("s5_run_idx", run_idx, 3);
    chk("s5_last_cycles", last_cycles, 7);

    // Spurious done in IDLE is ignored
    f0 = fin_seen;
    @(posedge clock); #1 spur_done = 1'b1;
    @(posedge clock); #1 spur_done = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_pass_cnt", pass_cnt, 3);
    chk("idle_fail_cnt", fail_cnt, 1);
    chk("idle_last_cycles", last_cycles, 7);
    chk("idle_finished", fin_seen - f0, 0);
    chk("idle_starts", seq_starts, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
